// File: rtl/mem_arbiter_rr_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : mem_arbiter_rr_pkg                                                |
// | Purpose : shared types and sizing helpers for the memory-port arbiter.      |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
package mem_arbiter_rr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   // A single port still needs a one-bit index so every select stays legal.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wait_cnt_bits(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : rr_picker                                                         |
// | Purpose : combinational rotate-priority / fixed-priority grant encoder.     |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module rr_picker
   import mem_arbiter_rr_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int IDX_BITS       = 1,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic [NUM_PORTS-1:0] i_eligible,
   input  logic [IDX_BITS-1:0]  i_last,
   output logic [IDX_BITS-1:0]  o_grant,
   output logic                 o_any_valid
);

   logic [2*NUM_PORTS-1:0] w_dbl;
   logic [NUM_PORTS-1:0]   w_rot;
   logic [IDX_BITS:0]      w_start;
   int                     w_off;

   assign w_dbl       = {i_eligible, i_eligible};
   assign w_start     = {1'b0, i_last} + (IDX_BITS + 1)'(1);
   assign o_any_valid = |i_eligible;

   // Rotating so that port last+1 lands at bit 0 turns RR into a lowest-set-bit search.
   always_comb begin
      w_rot   = NUM_PORTS'(w_dbl >> w_start);
      w_off   = 0;
      o_grant = '0;
      if (FIXED_PRIORITY != 0) begin
         for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (i_eligible[j]) o_grant = IDX_BITS'(j);
         end
      end else begin
         for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (w_rot[j]) w_off = j;
         end
         o_grant = IDX_BITS'((int'(w_start) + w_off) % NUM_PORTS);
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : mem_arbiter_rr                                                    |
// | Purpose : N-port request-driven arbiter onto one shared memory port.        |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module mem_arbiter_rr
   import mem_arbiter_rr_pkg::*;
#(
   parameter int NUM_CACHES     = 2,
   parameter int ADDRESS_BITS   = 64,
   parameter int DATA_BITS      = 512,
   parameter int FIXED_PRIORITY = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_CACHES-1:0][ADDRESS_BITS-1:0] p_addr,
   input  logic [NUM_CACHES-1:0][DATA_BITS-1:0]    p_write_data,
   input  logic [NUM_CACHES-1:0]                   p_read_en,
   input  logic [NUM_CACHES-1:0]                   p_write_en,
   output logic [NUM_CACHES-1:0][DATA_BITS-1:0]    p_read_data,
   output logic [NUM_CACHES-1:0]                   p_done,
   output logic [NUM_CACHES-1:0]                   p_error,
   output logic [NUM_CACHES-1:0]                   p_stall,
   output logic [ADDRESS_BITS-1:0]                 m_addr,
   output logic [DATA_BITS-1:0]                    m_write_data,
   output logic                                    m_read_en,
   output logic                                    m_write_en,
   input  logic [DATA_BITS-1:0]                    m_read_data,
   input  logic                                    m_stall
);

   localparam int c_IDX_BITS = idx_bits(NUM_CACHES);
   localparam int c_CNT_BITS = wait_cnt_bits(TIMEOUT_CYCLES);
   localparam logic [c_CNT_BITS-1:0] c_CNT_LAST =
      c_CNT_BITS'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [c_IDX_BITS-1:0] c_LAST_RST = c_IDX_BITS'(NUM_CACHES - 1);

   arb_state_t              r_state;
   arb_state_t              w_next_state;
   logic [c_IDX_BITS-1:0]   r_serving;
   logic [c_IDX_BITS-1:0]   r_last;
   logic [c_CNT_BITS-1:0]   r_wait_cnt;
   logic [NUM_CACHES-1:0]   w_req;
   logic [NUM_CACHES-1:0]   w_eligible;
   logic [c_IDX_BITS-1:0]   w_grant;
   logic                    w_any;
   logic                    w_timeout;

   assign w_req      = p_read_en | p_write_en;
   // A port whose done pulse is showing cannot be re-granted in that same cycle.
   assign w_eligible = w_req & ~p_done;
   assign p_stall    = w_req & ~p_done;
   assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == c_CNT_LAST);

   rr_picker #(
      .NUM_PORTS      (NUM_CACHES),
      .IDX_BITS       (c_IDX_BITS),
      .FIXED_PRIORITY (FIXED_PRIORITY)
   ) u_picker (
      .i_eligible  (w_eligible),
      .i_last      (r_last),
      .o_grant     (w_grant),
      .o_any_valid (w_any)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_any) w_next_state = ST_ISSUE;
         ST_ISSUE: w_next_state = ST_WAIT;
         ST_WAIT:  if (!m_stall || w_timeout) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_serving    <= '0;
         r_last       <= c_LAST_RST;
         r_wait_cnt   <= '0;
         m_addr       <= '0;
         m_write_data <= '0;
         m_read_en    <= 1'b0;
         m_write_en   <= 1'b0;
         p_read_data  <= '0;
         p_done       <= '0;
         p_error      <= '0;
      end else begin
         m_read_en  <= 1'b0;
         m_write_en <= 1'b0;
         p_done     <= '0;
         p_error    <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) r_serving <= w_grant;
            end
            ST_ISSUE: begin
               m_addr       <= p_addr[r_serving];
               m_write_data <= p_write_data[r_serving];
               m_write_en   <= p_write_en[r_serving];
               m_read_en    <= p_read_en[r_serving] & ~p_write_en[r_serving];
               r_wait_cnt   <= '0;
            end
            ST_WAIT: begin
               if (!m_stall) begin
                  p_read_data[r_serving] <= m_read_data;
                  p_done[r_serving]      <= 1'b1;
                  r_last                 <= r_serving;
               end else if (w_timeout) begin
                  p_done[r_serving]  <= 1'b1;
                  p_error[r_serving] <= 1'b1;
                  r_last             <= r_serving;
               end else if (r_wait_cnt != {c_CNT_BITS{1'b1}}) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_mem_arbiter_rr                                                 |
// | Purpose : randomized scoreboard bench, one RR/timeout lane and one fixed lane|
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_mem_arbiter_rr;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 32;

   typedef struct {
      int            cyc;
      bit            rd;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
   } cmd_t;

   typedef struct {
      int cyc;
      int port;
      bit err;
   } done_t;

   logic clk;
   logic rst;
   int   phase  = 0;
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input int lane, input string nm, input int cyc,
                               input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL lane%0d cyc%0d %s: got %0h expected %0h", lane, cyc, nm, act, exp);
      end
   endfunction

   // Arbitration rule: fixed = lowest index; RR = first eligible after last, wrapping.
   function automatic int pick(input logic [N-1:0] elig, input int last, input int fixed);
      if (fixed != 0) begin
         for (int i = 0; i < N; i++) if (elig[i]) return i;
      end else begin
         for (int k = 1; k <= N; k++) if (elig[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int FIX = g;
      localparam int TO  = (g == 0) ? 4 : 0;

      logic [N-1:0][AW-1:0] p_addr;
      logic [N-1:0][DW-1:0] p_write_data;
      logic [N-1:0]         p_read_en;
      logic [N-1:0]         p_write_en;
      logic [N-1:0][DW-1:0] p_read_data;
      logic [N-1:0]         p_done;
      logic [N-1:0]         p_error;
      logic [N-1:0]         p_stall;
      logic [AW-1:0]        m_addr;
      logic [DW-1:0]        m_write_data;
      logic                 m_read_en;
      logic                 m_write_en;
      logic [DW-1:0]        m_read_data;
      logic                 m_stall;

      mem_arbiter_rr #(
         .NUM_CACHES     (N),
         .ADDRESS_BITS   (AW),
         .DATA_BITS      (DW),
         .FIXED_PRIORITY (FIX),
         .TIMEOUT_CYCLES (TO)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .p_addr       (p_addr),
         .p_write_data (p_write_data),
         .p_read_en    (p_read_en),
         .p_write_en   (p_write_en),
         .p_read_data  (p_read_data),
         .p_done       (p_done),
         .p_error      (p_error),
         .p_stall      (p_stall),
         .m_addr       (m_addr),
         .m_write_data (m_write_data),
         .m_read_en    (m_read_en),
         .m_write_en   (m_write_en),
         .m_read_data  (m_read_data),
         .m_stall      (m_stall)
      );

      cmd_t          cmdq[$];
      done_t         doneq[$];
      logic [DW-1:0] mrd [N];
      int            mcyc = 0, ncyc = 0, ncmd = 0, ndone = 0, nerr = 0;
      bit            busy = 0, issue_pend = 0, mask_v = 0;
      int            cmd_cyc = 0, srv = 0, last = N - 1, mask_p = 0;
      logic [N-1:0]  req_on;
      logic [N-1:0]  elig;
      cmd_t          mc, mc2;
      done_t         md, md2;
      logic [N-1:0]  exp_done, exp_err;
      bit            cmd_exp;
      int            t;

      // Reference model: transaction timeline predicted at each rising edge.
      initial forever begin
         @(posedge clk);
         mcyc++;
         if (rst) begin
            busy = 0; issue_pend = 0; mask_v = 0; last = N - 1;
            cmdq.delete();
            doneq.delete();
            for (int i = 0; i < N; i++) mrd[i] = '0;
         end else if (issue_pend) begin
            mc.cyc  = mcyc;
            mc.wr   = p_write_en[srv];
            mc.rd   = p_read_en[srv] & ~p_write_en[srv];
            mc.addr = p_addr[srv];
            mc.wd   = p_write_data[srv];
            cmdq.push_back(mc);
            issue_pend = 0; busy = 1; cmd_cyc = mcyc;
         end else if (busy) begin
            if (!m_stall || (TO != 0 && mcyc - cmd_cyc == TO)) begin
               md.cyc = mcyc; md.port = srv; md.err = m_stall;
               doneq.push_back(md);
               if (!m_stall) mrd[srv] = m_read_data;
               busy = 0; last = srv; mask_v = 1; mask_p = srv;
            end
         end else begin
            elig = p_read_en | p_write_en;
            if (mask_v) elig[mask_p] = 1'b0;
            mask_v = 0;
            srv = pick(elig, last, FIX);
            if (srv >= 0) issue_pend = 1;
            else srv = 0;
         end
      end

      // Monitor: pops whatever the model expects for this cycle and compares.
      initial forever begin
         @(negedge clk);
         ncyc++;
         exp_done = '0; exp_err = '0; cmd_exp = 0;
         if (doneq.size() > 0 && doneq[0].cyc == ncyc) begin
            md2 = doneq.pop_front();
            exp_done[md2.port] = 1'b1;
            exp_err[md2.port]  = md2.err;
            ndone++;
            if (md2.err) nerr++;
         end
         if (cmdq.size() > 0 && cmdq[0].cyc == ncyc) begin
            mc2 = cmdq.pop_front();
            cmd_exp = 1;
         end else begin
            mc2.cyc = 0; mc2.rd = 0; mc2.wr = 0; mc2.addr = '0; mc2.wd = '0;
         end
         chk(g, "p_done", ncyc, 64'(p_done), 64'(exp_done));
         chk(g, "p_error", ncyc, 64'(p_error), 64'(exp_err));
         chk(g, "p_stall", ncyc, 64'(p_stall), 64'((p_read_en | p_write_en) & ~exp_done));
         chk(g, "m_read_en", ncyc, 64'(m_read_en), 64'(mc2.rd));
         chk(g, "m_write_en", ncyc, 64'(m_write_en), 64'(mc2.wr));
         if (cmd_exp) begin
            chk(g, "m_addr", ncyc, 64'(m_addr), 64'(mc2.addr));
            chk(g, "m_write_data", ncyc, 64'(m_write_data), 64'(mc2.wd));
            if (mc2.rd || mc2.wr) ncmd++;
         end
         if (rst) begin
            chk(g, "rst_m_addr", ncyc, 64'(m_addr), 64'(0));
            chk(g, "rst_m_write_data", ncyc, 64'(m_write_data), 64'(0));
         end
         for (int i = 0; i < N; i++)
            chk(g, "p_read_data", ncyc, 64'(p_read_data[i]), 64'(mrd[i]));
      end

      // Per-lane stimulus: cache ports and a randomly stalling memory.
      initial begin
         p_addr = '0; p_write_data = '0; p_read_en = '0; p_write_en = '0;
         m_stall = 1'b0; m_read_data = '0; req_on = '0;
         forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
               if (req_on[i] && p_done[i] && phase != 1 && $urandom_range(1, 0) == 0) begin
                  req_on[i] = 1'b0; p_read_en[i] = 1'b0; p_write_en[i] = 1'b0;
               end else if ((req_on[i] && p_done[i]) ||
                            (!req_on[i] && (phase == 1 || $urandom_range(3, 0) == 0))) begin
                  req_on[i]       = 1'b1;
                  p_addr[i]       = AW'($urandom);
                  p_write_data[i] = $urandom;
                  t = $urandom_range(2, 0);
                  p_read_en[i]    = (t != 1);
                  p_write_en[i]   = (t != 0);
               end else if (req_on[i] && phase == 3 && $urandom_range(15, 0) == 0) begin
                  req_on[i] = 1'b0; p_read_en[i] = 1'b0; p_write_en[i] = 1'b0;
               end
            end
            if (phase == 1)      m_stall = 1'b0;
            else if (phase == 2) m_stall = ($urandom_range(9, 0) < 8);
            else                 m_stall = ($urandom_range(2, 0) == 0);
            m_read_data = $urandom;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   initial begin
      int w;
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      phase = 0;
      cyc(400);
      phase = 1;
      cyc(300);
      phase = 2;
      cyc(400);
      w = 0;
      while (!g_lane[0].busy && w < 100) begin
         cyc(1);
         w++;
      end
      chk(0, "wait_before_reset", w, 64'(g_lane[0].busy), 64'(1));
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      phase = 3;
      cyc(400);
      phase = 0;
      cyc(200);
      chk(0, "commands_seen", 0, 64'(g_lane[0].ncmd > 100), 64'(1));
      chk(1, "commands_seen", 0, 64'(g_lane[1].ncmd > 100), 64'(1));
      chk(0, "timeouts_seen", 0, 64'(g_lane[0].nerr > 0), 64'(1));
      chk(1, "no_timeouts", 0, 64'(g_lane[1].nerr), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
